// File: rtl/mem_req_queue.sv
// Time-gated trace request FIFO: decodes DDR5 address fields at enqueue and releases
// the head entry once the internal CPU-cycle clock reaches its timestamp. Optional: QUEUE_FFWD_EN.
module mem_req_queue #(
  parameter int QUEUE_DEPTH   = 16,
  parameter int CPU_CYC_WIDTH = 64,
  parameter int CORE_WIDTH    = 4,
  parameter int OPN_WIDTH     = 3,
  parameter int ADDR_WIDTH    = 34
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CPU_CYC_WIDTH-1:0]         in_cpu_cyc,
  input  logic [CORE_WIDTH-1:0]            in_core,
  input  logic [OPN_WIDTH-1:0]             in_opn,
  input  logic [ADDR_WIDTH-1:0]            in_addr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CPU_CYC_WIDTH-1:0]         out_cpu_cyc,
  output logic [CORE_WIDTH-1:0]            out_core,
  output logic [OPN_WIDTH-1:0]             out_opn,
  output logic [15:0]                      out_row,
  output logic [9:0]                       out_col,
  output logic [1:0]                       out_bank,
  output logic [2:0]                       out_bg,
  output logic                             out_channel,
  output logic [1:0]                       out_byte,
  output logic [CPU_CYC_WIDTH-1:0]         cpu_clock,
  output logic [$clog2(QUEUE_DEPTH):0]     count,
  output logic                             full,
  output logic                             empty,
  output logic                             err_opn,
  output logic                             err_order
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [CPU_CYC_WIDTH-1:0] sat_inc(input logic [CPU_CYC_WIDTH-1:0] v);
    return (&v) ? v : v + CPU_CYC_WIDTH'(1);
  endfunction

  logic [CPU_CYC_WIDTH-1:0] cyc_mem  [QUEUE_DEPTH];
  logic [CORE_WIDTH-1:0]    core_mem [QUEUE_DEPTH];
  logic [OPN_WIDTH-1:0]     opn_mem  [QUEUE_DEPTH];
  logic [15:0]              row_mem  [QUEUE_DEPTH];
  logic [9:0]               col_mem  [QUEUE_DEPTH];
  logic [1:0]               bank_mem [QUEUE_DEPTH];
  logic [2:0]               bg_mem   [QUEUE_DEPTH];
  logic                     ch_mem   [QUEUE_DEPTH];
  logic [1:0]               byte_mem [QUEUE_DEPTH];

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CPU_CYC_WIDTH-1:0] clk_q, clk_d;
  logic [CPU_CYC_WIDTH-1:0] last_q, last_d;
  logic                     err_opn_q, err_opn_d;
  logic                     err_order_q, err_order_d;

  logic                     accept, opn_legal, push, pop, eligible;
  logic [CPU_CYC_WIDTH-1:0] head_cyc;

  assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign opn_legal = (in_opn <= OPN_WIDTH'(2));
  assign accept    = in_valid && in_ready;
  assign push      = accept && opn_legal;

  assign head_cyc  = cyc_mem[rd_ptr_q];
  assign eligible  = (head_cyc <= clk_q);
  assign out_valid = !empty && eligible;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_d      = last_q;
    err_opn_d   = err_opn_q;
    err_order_d = err_order_q;
    clk_d       = sat_inc(clk_q);

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      last_d   = in_cpu_cyc;
      if (in_cpu_cyc < last_q) err_order_d = 1'b1;
    end
    if (accept && !opn_legal) err_opn_d = 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

`ifdef QUEUE_FFWD_EN
    // Jump over idle trace gaps; the +1 is widened so an all-ones clock cannot wrap.
    if (!empty && ({1'b0, head_cyc} > ({1'b0, clk_q} + (CPU_CYC_WIDTH+1)'(1))))
      clk_d = head_cyc;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      clk_q       <= '0;
      last_q      <= '0;
      err_opn_q   <= 1'b0;
      err_order_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      clk_q       <= clk_d;
      last_q      <= last_d;
      err_opn_q   <= err_opn_d;
      err_order_q <= err_order_d;
    end
  end

  // Address fields are decoded here so the read side is a plain mux.
  always_ff @(posedge clk) begin
    if (push) begin
      cyc_mem[wr_ptr_q]  <= in_cpu_cyc;
      core_mem[wr_ptr_q] <= in_core;
      opn_mem[wr_ptr_q]  <= in_opn;
      row_mem[wr_ptr_q]  <= in_addr[33:18];
      col_mem[wr_ptr_q]  <= {in_addr[17:12], in_addr[5:2]};
      bank_mem[wr_ptr_q] <= in_addr[11:10];
      bg_mem[wr_ptr_q]   <= in_addr[9:7];
      ch_mem[wr_ptr_q]   <= in_addr[6];
      byte_mem[wr_ptr_q] <= in_addr[1:0];
    end
  end

  // Storage is not reset, so head fields are forced to zero while the queue is empty.
  assign out_cpu_cyc = empty ? '0   : head_cyc;
  assign out_core    = empty ? '0   : core_mem[rd_ptr_q];
  assign out_opn     = empty ? '0   : opn_mem[rd_ptr_q];
  assign out_row     = empty ? '0   : row_mem[rd_ptr_q];
  assign out_col     = empty ? '0   : col_mem[rd_ptr_q];
  assign out_bank    = empty ? '0   : bank_mem[rd_ptr_q];
  assign out_bg      = empty ? '0   : bg_mem[rd_ptr_q];
  assign out_channel = empty ? 1'b0 : ch_mem[rd_ptr_q];
  assign out_byte    = empty ? '0   : byte_mem[rd_ptr_q];

  assign cpu_clock = clk_q;
  assign count     = count_q;
  assign err_opn   = err_opn_q;
  assign err_order = err_order_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// Scoreboard bench for mem_req_queue: a queue-based reference model tracks accepted
// entries and the CPU clock; a negedge monitor compares every DUT output against it.
module tb_mem_req_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_cpu_cyc = '0;
  logic [3:0]  in_core = '0;
  logic [2:0]  in_opn = '0;
  logic [33:0] in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_cpu_cyc;
  logic [3:0]  out_core;
  logic [2:0]  out_opn;
  logic [15:0] out_row;
  logic [9:0]  out_col;
  logic [1:0]  out_bank;
  logic [2:0]  out_bg;
  logic        out_channel;
  logic [1:0]  out_byte;
  logic [63:0] cpu_clock;
  logic [4:0]  count;
  logic        full, empty, err_opn, err_order;

  mem_req_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cpu_cyc(in_cpu_cyc),
    .in_core(in_core), .in_opn(in_opn), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_cpu_cyc(out_cpu_cyc),
    .out_core(out_core), .out_opn(out_opn), .out_row(out_row), .out_col(out_col),
    .out_bank(out_bank), .out_bg(out_bg), .out_channel(out_channel), .out_byte(out_byte),
    .cpu_clock(cpu_clock), .count(count), .full(full), .empty(empty),
    .err_opn(err_opn), .err_order(err_order)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: accepted entries in order plus the expected CPU clock and flags.
  typedef struct {
    logic [63:0] cyc;
    logic [3:0]  core;
    logic [2:0]  opn;
    logic [33:0] addr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mclk = '0;
  logic [63:0] mlast = '0;
  bit          merr_opn = 1'b0;
  bit          merr_order = 1'b0;

  function automatic bit m_valid();
    return (mq.size() > 0) && (mq[0].cyc <= mclk);
  endfunction

  initial begin
    bit   v, pp, acc;
    ent_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        mclk = '0; mlast = '0; merr_opn = 1'b0; merr_order = 1'b0;
      end else begin
        v   = m_valid();
        pp  = v && out_ready;
        acc = in_valid && (mq.size() < DEPTH);
`ifdef QUEUE_FFWD_EN
        if (mq.size() > 0 && {1'b0, mq[0].cyc} > {1'b0, mclk} + 65'd1) mclk = mq[0].cyc;
        else if (mclk != '1) mclk = mclk + 64'd1;
`else
        if (mclk != '1) mclk = mclk + 64'd1;
`endif
        if (pp) void'(mq.pop_front());
        if (acc) begin
          if (in_opn > 3'd2) merr_opn = 1'b1;
          else begin
            if (in_cpu_cyc < mlast) merr_order = 1'b1;
            mlast = in_cpu_cyc;
            e.cyc = in_cpu_cyc; e.core = in_core; e.opn = in_opn; e.addr = in_addr;
            mq.push_back(e);
          end
        end
      end
    end
  end

  // Monitor: compares the presented head and status against the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", 64'(out_valid), 64'(m_valid()));
        if (m_valid() && out_valid) begin
          chk("out_cpu_cyc", out_cpu_cyc, mq[0].cyc);
          chk("out_core",    64'(out_core),    64'(mq[0].core));
          chk("out_opn",     64'(out_opn),     64'(mq[0].opn));
          chk("out_row",     64'(out_row),     64'(mq[0].addr[33:18]));
          chk("out_col",     64'(out_col),     64'({mq[0].addr[17:12], mq[0].addr[5:2]}));
          chk("out_bank",    64'(out_bank),    64'(mq[0].addr[11:10]));
          chk("out_bg",      64'(out_bg),      64'(mq[0].addr[9:7]));
          chk("out_channel", 64'(out_channel), 64'(mq[0].addr[6]));
          chk("out_byte",    64'(out_byte),    64'(mq[0].addr[1:0]));
        end
        chk("count",     64'(count),     64'(mq.size()));
        chk("full",      64'(full),      64'(mq.size() == DEPTH));
        chk("empty",     64'(empty),     64'(mq.size() == 0));
        chk("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
        chk("cpu_clock", cpu_clock,      mclk);
        chk("err_opn",   64'(err_opn),   64'(merr_opn));
        chk("err_order", 64'(err_order), 64'(merr_order));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] cyc, input logic [3:0] core,
                       input logic [2:0] opn, input logic [33:0] addr);
    in_valid = 1'b1; in_cpu_cyc = cyc; in_core = core; in_opn = opn; in_addr = addr;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_empty"},     64'(empty),     64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_count"},     64'(count),     64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_full"},      64'(full),      64'd0);
    chk({tag, "_cpu_clock"}, cpu_clock,      64'd0);
    chk({tag, "_errs"},      64'({err_opn, err_order}), 64'd0);
    chk({tag, "_fields"},    64'({out_row, out_col, out_bank, out_bg, out_channel, out_byte}), 64'd0);
    chk({tag, "_out_cyc"},   out_cpu_cyc, 64'd0);
  endtask

  // Asynchronous reset asserted between edges, checked before the next edge.
  task automatic mid_reset(input string tag);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 reset_checks(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while (!empty && k < 200) begin step(); k++; end
    chk({tag, "_drained"}, 64'(empty), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] r64, ts, cc;
    int          k;
    logic [4:0]  cnt0;

    step(); step();
    reset_checks("reset");
    rst = 1'b0;

    // Decode example entry.
    drive(64'd0, 4'd3, 3'd0, 34'h1_2345_6789);
    step();
    in_valid = 1'b0;
    chk("dec_valid", 64'(out_valid), 64'd1);
    chk("dec_row",   64'(out_row),   64'h48D1);
    chk("dec_col",   64'(out_col),   64'h162);
    chk("dec_bank",  64'(out_bank),  64'd1);
    chk("dec_bg",    64'(out_bg),    64'd7);
    chk("dec_ch",    64'(out_channel), 64'd0);
    chk("dec_byte",  64'(out_byte),  64'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("dec_popped", 64'(empty), 64'd1);

    // Fill to full, then entry 17 waits for the first pop.
    for (int i = 0; i < DEPTH; i++) begin
      r64 = {$urandom, $urandom};
      drive(64'd0, 4'(i), 3'(i % 3), r64[33:0]);
      step();
    end
    r64 = {$urandom, $urandom};
    drive(64'd0, 4'hF, 3'd2, r64[33:0]);
    step();
    chk("fill_full",     64'(full),     64'd1);
    chk("fill_count",    64'(count),    64'd16);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    chk("pop_while_full_count", 64'(count), 64'd15);
    step();
    chk("push17_count", 64'(count), 64'd15);
    drain("fill");

    // Simultaneous push and pop at count 3.
    for (int i = 0; i < 3; i++) begin
      r64 = {$urandom, $urandom};
      drive(64'd0, 4'(i), 3'd1, r64[33:0]);
      step();
    end
    chk("pp_count_before", 64'(count), 64'd3);
    r64 = {$urandom, $urandom};
    drive(64'd0, 4'd9, 3'd0, r64[33:0]);
    out_ready = 1'b1;
    step();
    chk("pp_count_after", 64'(count), 64'd3);
    drain("pp");

    // Illegal opcode and out-of-order timestamps.
    cnt0 = count;
    drive(64'd0, 4'd1, 3'd5, 34'h0);
    step(); in_valid = 1'b0;
    chk("opn_err",   64'(err_opn), 64'd1);
    chk("opn_count", 64'(count),   64'(cnt0));
    drive(64'd10, 4'd2, 3'd0, 34'h3_0000_0000); step();
    drive(64'd4,  4'd2, 3'd1, 34'h0_0000_0FFF); step();
    in_valid = 1'b0;
    chk("order_err",   64'(err_order), 64'd1);
    chk("order_count", 64'(count),     64'(cnt0) + 64'd2);
    drain("order");

    // Time gating: timestamp 20 pushed while cpu_clock is 3.
    mid_reset("rst_a");
    k = 0;
    while (cpu_clock != 64'd3 && k < 10) begin step(); k++; end
    drive(64'd20, 4'd5, 3'd2, 34'h2_AAAA_5555);
    step(); in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin step(); k++; end
    chk("gate_valid", 64'(out_valid), 64'd1);
    chk("gate_clock", cpu_clock,      64'd20);
    drain("gate");

    // Randomised traffic with a mid-stream reset.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) mid_reset("rst_mid");
      cc = mclk;
      if ($urandom_range(0, 9) == 0 && cc > 64'd5) ts = cc - 64'($urandom_range(1, 5));
      else ts = cc + 64'($urandom_range(0, 12));
      r64 = {$urandom, $urandom};
      in_valid   = ($urandom_range(0, 9) < 6);
      in_cpu_cyc = ts;
      in_core    = 4'($urandom);
      in_opn     = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      in_addr    = r64[33:0];
      out_ready  = ($urandom_range(0, 9) < 6);
      step();
    end
    drain("final");
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_req_queue.md
# mem_req_queue

Time-gated request queue between the trace parser and the DDR5 command scheduler. It accepts one parsed trace entry per cycle (CPU cycle, core, operation, 34-bit address) over a valid/ready handshake and buffers it in a circular FIFO. It decodes the address into DDR5 row/column/bank/bank-group/channel fields. Each entry is released to the scheduler only once the block's internal CPU-cycle clock reaches the entry's timestamp.

## Interface
- QUEUE_DEPTH, 16, FIFO entries; power of two, minimum 2.
- CPU_CYC_WIDTH, 64, trace timestamp and internal clock width.
- CORE_WIDTH, 4, core ID width.
- OPN_WIDTH, 3, operation code width.
- ADDR_WIDTH, 34, physical address width; the decode map below is fixed for 34.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  parser offers an entry.
- in_ready  out  1  entry is accepted when in_valid && in_ready.
- in_cpu_cyc  in  CPU_CYC_WIDTH  trace timestamp.
- in_core  in  CORE_WIDTH  issuing core.
- in_opn  in  OPN_WIDTH  0 = data read, 1 = data write, 2 = instruction fetch; other codes are illegal.
- in_addr  in  ADDR_WIDTH  physical address.
- out_valid  out  1  head entry is present and eligible.
- out_ready  in  1  scheduler takes the head entry.
- out_cpu_cyc, out_core, out_opn  out  as input  head entry fields.
- out_row  out  16  addr[33:18].
- out_col  out  10  {addr[17:12], addr[5:2]}.
- out_bank  out  2  addr[11:10].
- out_bg  out  3  addr[9:7].
- out_channel  out  1  addr[6].
- out_byte  out  2  addr[1:0].
- cpu_clock  out  CPU_CYC_WIDTH  internal CPU-cycle count.
- count  out  $clog2(QUEUE_DEPTH)+1  current occupancy.
- full, empty  out  1  status flags.
- err_opn, err_order  out  1  sticky error flags.

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(QUEUE_DEPTH) bits and wrapping modulo the depth, plus a separate occupancy counter.
- Address fields are decoded at enqueue and stored, so no decode logic sits on the output path.
- in_ready = !full. It is purely a function of occupancy, with no dependence on out_ready.
- Accept with in_opn > 2: the entry is dropped (no write, count unchanged) and err_opn is set.
- Accept with in_cpu_cyc < last accepted timestamp: the entry is enqueued normally and err_order is set.
  - The last-accepted register updates only on legal accepts.
- Eligibility: head entry cpu_cyc <= cpu_clock. out_valid = !empty && eligible.
- Output fields are driven from the head entry and stay stable while out_valid && !out_ready.
- Pop when out_valid && out_ready. rd_ptr advances and count decrements.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- cpu_clock increments by 1 every cycle and saturates at all-ones.
- Error flags clear only on rst.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, empty = 1, full = 0, count = 0.
  - cpu_clock = 0, err_opn = 0, err_order = 0, pointers = 0.
  - All out_* data fields = 0.
- Enqueue-to-visible latency is 1 cycle. An entry accepted at edge N can assert out_valid in the cycle after edge N, if it is eligible. There is no empty-queue bypass.
- Entry with timestamp T: out_valid rises in the first cycle in which cpu_clock >= T. Once eligible, the head stays eligible until it is popped.
- When full, in_ready = 0 even if a pop occurs in the same cycle.
- Reset asserted mid-operation discards all entries immediately. Outputs return to reset values asynchronously.

## Configuration
- QUEUE_FFWD_EN defined: when the queue is non-empty and the head timestamp is greater than cpu_clock + 1, cpu_clock loads the head timestamp on the next edge instead of incrementing. This skips idle trace gaps; the head becomes eligible 1 cycle after the jump.
- QUEUE_FFWD_EN undefined: cpu_clock only increments. No fast-forward logic is present.

## Test plan
- Reset, then push in_cpu_cyc = 0, in_opn = 0, in_addr = 34'h1_2345_6789 -> next cycle out_valid = 1, out_row = 16'h48D1, out_col = 10'h162, out_bank = 1, out_bg = 7, out_channel = 0, out_byte = 1.
- Push 16 entries with timestamp 0 and out_ready = 0 -> full = 1, count = 16, in_ready = 0. Then hold out_ready = 1 -> entries drain in order and pointers wrap; push entry 17 -> it is accepted only after the first pop.
- Without QUEUE_FFWD_EN, push timestamp 20 at cpu_clock = 3 -> out_valid stays 0 until cpu_clock = 20.
- With QUEUE_FFWD_EN, the same stimulus -> cpu_clock jumps to 20 and out_valid = 1 on the following cycle.
- Push opn = 5 -> err_opn = 1 and count is unchanged. Push timestamps 10 then 4 -> err_order = 1 and both entries are queued.
- Push and pop simultaneously at count = 3 -> count stays 3 and out fields step to the next entry. Assert rst mid-stream -> empty = 1 and out_valid = 0 immediately.
